// File: rtl/sum_to_bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package sum_to_bcd_pkg;

  localparam int unsigned IN_WIDTH   = 10;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned CNT_WIDTH  = $clog2(IN_WIDTH) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sum_to_bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Valid digits are <= 9, so the 4-bit result never exceeds 12 and needs no carry.
  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/sum_to_bcd.sv
// Sequential shift-and-add-3 converter: one input bit per clock, registered digits
// and a one-cycle done pulse when a conversion completes.
module sum_to_bcd #(
  parameter int unsigned IN_WIDTH   = sum_to_bcd_pkg::IN_WIDTH,
  parameter int unsigned NUM_DIGITS = sum_to_bcd_pkg::NUM_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic [3:0]          bcd_thousands,
  output logic [3:0]          bcd_hundreds,
  output logic [3:0]          bcd_tens,
  output logic [3:0]          bcd_ones
);

  import sum_to_bcd_pkg::*;

  localparam int unsigned CNT_W = $clog2(IN_WIDTH) + 1;
  localparam int unsigned SCR_W = 4 * NUM_DIGITS;

  state_e              r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [SCR_W-1:0]    r_scratch;
  logic [CNT_W-1:0]    r_cnt;
  logic [SCR_W-1:0]    r_bcd;
  logic                r_done;

  logic [SCR_W-1:0]    w_adj;
  logic [SCR_W-1:0]    w_scratch_next;
  logic [IN_WIDTH-1:0] w_bin_next;
  logic                w_last;
  logic                w_accept;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit(r_scratch[4*g +: 4]),
      .o_digit(w_adj[4*g +: 4])
    );
  end

  // {scratch, bin} shifted left by one after the digit correction.
  assign w_scratch_next = {w_adj[SCR_W-2:0], r_bin[IN_WIDTH-1]};
  assign w_bin_next     = {r_bin[IN_WIDTH-2:0], 1'b0};

  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1));
  assign w_accept = start && ((r_state == ST_IDLE) || w_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_SHIFT) begin
        r_scratch <= w_scratch_next;
        r_bin     <= w_bin_next;
        r_cnt     <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_bcd   <= w_scratch_next;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
      end
      // Acceptance overrides the completion bookkeeping so back-to-back runs keep busy high.
      if (w_accept) begin
        r_bin     <= bin_in;
        r_scratch <= '0;
        r_cnt     <= CNT_W'(IN_WIDTH);
        r_state   <= ST_SHIFT;
      end
    end
  end

  assign busy          = (r_state == ST_SHIFT);
  assign done          = r_done;
  assign bcd_ones      = r_bcd[3:0];
  assign bcd_tens      = r_bcd[7:4];
  assign bcd_hundreds  = r_bcd[11:8];
  assign bcd_thousands = r_bcd[15:12];

endmodule

// File: tb/tb_sum_to_bcd.sv
// Scoreboard bench for sum_to_bcd: drivers queue expected digits, a monitor checks each done.
module tb_sum_to_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] bin_in;
  logic       busy;
  logic       done;
  logic [3:0] bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] sb_q[$];
  logic        prev_done = 1'b0;

  sum_to_bcd u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bin_in       (bin_in),
    .busy         (busy),
    .done         (done),
    .bcd_thousands(bcd_thousands),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      check("done_not_consecutive", int'(prev_done), 0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got %0h, expected no pulse",
                 {bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones});
      end else begin
        check("digits", int'({bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones}),
              int'(sb_q.pop_front()));
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic start_conv(input logic [9:0] v);
    @(posedge clk); #1;
    bin_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic run_conv(input logic [9:0] v, input logic [15:0] exp, input bit chk_busy);
    int cnt;
    wait_idle();
    sb_q.push_back(exp);
    start_conv(v);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy || cnt > 40) break;
      cnt++;
    end
    if (chk_busy) begin
      check("busy_cycles", cnt, 10);
      check("done_with_busy_drop", int'(done), 1);
    end
  endtask

  initial begin
    int dones, low, t, t1, t2, unstable;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_digits", int'({bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones}), 0);

    run_conv(10'd0,    16'h0000, 1'b1);
    run_conv(10'd1022, 16'h1022, 1'b1);
    run_conv(10'd1023, 16'h1023, 1'b1);
    run_conv(10'd999,  16'h0999, 1'b0);
    run_conv(10'd9,    16'h0009, 1'b0);
    run_conv(10'd10,   16'h0010, 1'b0);

    // Back-to-back: start held high, bin_in changes mid-run, accepted on completion edge.
    wait_idle();
    sb_q.push_back(16'h1022);
    sb_q.push_back(16'h0005);
    @(posedge clk); #1;
    bin_in = 10'd1022;
    start  = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1 bin_in = 10'd5;
    dones = 0; low = 0; t = 0; t1 = 0; t2 = 0;
    while (dones < 2 && t < 60) begin
      @(negedge clk);
      t++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          t1    = t;
          start = 1'b0;
        end else begin
          t2 = t;
        end
      end
      if (dones < 2 && !busy) low++;
    end
    check("b2b_dones", dones, 2);
    check("b2b_busy_low", low, 0);
    check("b2b_gap", t2 - t1, 10);

    // Previous result must hold on the outputs until the next done.
    run_conv(10'd123, 16'h0123, 1'b0);
    wait_idle();
    sb_q.push_back(16'h0456);
    start_conv(10'd456);
    unstable = 0; t = 0;
    forever begin
      @(negedge clk);
      t++;
      if (done || t > 40) break;
      if ({bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones} != 16'h0123) unstable++;
    end
    check("hold_prev_digits", unstable, 0);

    // Reset in the middle of a conversion of 777 aborts it.
    wait_idle();
    start_conv(10'd777);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_digits", int'({bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones}), 0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    for (int v = 0; v < 1024; v++) run_conv(10'(v), model(v), 1'b0);

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_to_bcd.md
Name: sum_to_bcd

Overview:
- Sequential binary-to-BCD converter. It sits directly downstream of the 9-bit ripple adder and consumes that adder's 10-bit sum.
- Uses shift-and-add-3 (double-dabble), one bit per clock.
- Produces four registered BCD digits for the board's HEX display decoders.
- A start/busy/done handshake lets the game controller request a conversion whenever the score sum changes.

Parameters:
- IN_WIDTH, 10, width of the binary input; equals adder sum width (9+1).
- NUM_DIGITS, 4, number of BCD output digits; must satisfy 10^NUM_DIGITS > 2^IN_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only when the block can accept.
- bin_in  input  IN_WIDTH  binary value (adder sum); sampled on accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are valid.
- bcd_thousands  output  4  digit 3 (0 or 1 for 10-bit input).
- bcd_hundreds  output  4  digit 2.
- bcd_tens  output  4  digit 1.
- bcd_ones  output  4  digit 0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0; done=0; all digit outputs=0; shift/scratch registers=0; iteration counter=0. Reset dominates start in the same cycle.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - DONE is not a state; done is a registered pulse.
- Accept rule: start=1 is accepted on an edge when state=IDLE. It is also accepted on the edge where SHIFT completes (back-to-back).
- On acceptance:
  - bin_in is loaded into the binary shift register; the BCD scratch register is cleared.
  - The counter is set to IN_WIDTH.
  - State becomes SHIFT.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3 (combinational adjust).
  - The {scratch, binary} register then shifts left by 1.
  - The counter decrements by 1.
- When the counter reaches 1 on an edge (the final iteration):
  - The adjusted-and-shifted scratch result is written to the four bcd_* outputs.
  - done goes to 1 for exactly one cycle.
  - busy drops to 0, unless a new start is accepted on that edge, in which case busy stays 1.
- Latency: start accepted at edge E0; iterations at E1..E10; done=1 and new digits visible in the cycle after E10. That is 10 cycles from the accepting edge for IN_WIDTH=10.
- start while busy (other than the completion edge) is ignored and not queued. bin_in changes during SHIFT have no effect.
- Digit outputs hold their last value until the next completion. They never show intermediate values.
- done is never high on two consecutive cycles unless back-to-back conversions complete on consecutive runs. With a fixed 10-cycle length that cannot happen, so done must never be high 2 cycles in a row.
- Reset mid-conversion: the conversion is aborted, done stays 0, and all outputs clear to 0 on that edge.
- Width rules:
  - The scratch register is 4*NUM_DIGITS bits.
  - The +3 adjust is 4-bit with no carry out; a valid digit input is <=9, so the adjust result is <=12.
  - Full input range 0..2^IN_WIDTH-1 (0..1023) is supported, not just the adder's 0..1022.

Decomposition:
- Shared package/header constants: IN_WIDTH, NUM_DIGITS, state encodings (ST_IDLE=0, ST_SHIFT=1), counter width (clog2(IN_WIDTH)+1).
- One natural sub-module, bcd_digit_adjust: combinational, 4-bit in/out, out = in>=5 ? in+3 : in. Instantiated NUM_DIGITS times on the scratch register.

Test Plan:
- Reset, then bin_in=0, start pulse -> busy=1 for 10 cycles, done pulse on cycle 10, digits 0,0,0,0.
- bin_in=1022 (adder max, 511+511) -> digits 1,0,2,2 on done. bin_in=1023 -> 1,0,2,3.
- Sweep: bin_in=999 -> 0,9,9,9; bin_in=9 -> 0,0,0,9; bin_in=10 -> 0,0,1,0. Compare all 0..1023 against a divide/modulo model.
- start held high with bin_in changed to 5 at cycle 3 of a 1022 conversion -> result 1,0,2,2. Next conversion accepted on the completion edge returns 0,0,0,5 ten cycles later; busy never drops between the two.
- Reset asserted at cycle 5 of a conversion of 777 -> next cycle busy=0, done=0, digits 0,0,0,0. No done pulse follows.
- Outputs stable check: previous result 0,1,2,3 must remain on bcd_* throughout a following conversion of 456 until its done pulse, then change to 0,4,5,6.
